// File: rtl/reorder_buffer_mw_if.sv
// Dispatch, writeback, mispredict and commit bundle for reorder_buffer_mw.
// slave is the buffer side, master is the pipeline side driving it.
interface reorder_buffer_mw_if #(
  parameter int DEPTH  = 8,
  parameter int CMT_W  = 2,
  parameter int XLEN   = 32,
  parameter int PREG_W = 7,
  parameter int AREG_W = 6
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                    dp_valid;
  logic                    dp_ready;
  logic [XLEN-1:0]         dp_pc;
  logic [XLEN-1:0]         dp_inst;
  logic [PREG_W-1:0]       dp_prd_new;
  logic [PREG_W-1:0]       dp_prd_old;
  logic [AREG_W-1:0]       dp_ard;
  logic                    dp_wb_en;
  logic                    dp_is_st;
  logic                    dp_is_ld;
  logic [IDX_W-1:0]        dp_idx;
  logic                    wb_valid;
  logic [IDX_W-1:0]        wb_idx;
  logic [XLEN-1:0]         wb_data;
  logic                    mis_valid;
  logic [IDX_W-1:0]        mis_idx;
  logic [DEPTH-1:0]        flush_mask;
  logic [CMT_W-1:0]        cm_valid;
  logic [CMT_W-1:0]        cm_wb_en;
  logic [CMT_W*PREG_W-1:0] cm_prd_new;
  logic [CMT_W*PREG_W-1:0] cm_prd_old;
  logic [CMT_W*AREG_W-1:0] cm_ard;
  logic [CMT_W*XLEN-1:0]   cm_data;
  logic [CMT_W*XLEN-1:0]   cm_pc;
  logic [CMT_W*XLEN-1:0]   cm_inst;
  logic [1:0]              ld_commit;
  logic                    st_commit;
  logic                    recovery;
  logic [IDX_W:0]          count;

  modport slave (
    input  dp_valid, dp_pc, dp_inst, dp_prd_new, dp_prd_old, dp_ard, dp_wb_en, dp_is_st, dp_is_ld,
    input  wb_valid, wb_idx, wb_data, mis_valid, mis_idx,
    output dp_ready, dp_idx, flush_mask, cm_valid, cm_wb_en, cm_prd_new, cm_prd_old, cm_ard,
    output cm_data, cm_pc, cm_inst, ld_commit, st_commit, recovery, count
  );

  modport master (
    output dp_valid, dp_pc, dp_inst, dp_prd_new, dp_prd_old, dp_ard, dp_wb_en, dp_is_st, dp_is_ld,
    output wb_valid, wb_idx, wb_data, mis_valid, mis_idx,
    input  dp_ready, dp_idx, flush_mask, cm_valid, cm_wb_en, cm_prd_new, cm_prd_old, cm_ard,
    input  cm_data, cm_pc, cm_inst, ld_commit, st_commit, recovery, count
  );
endinterface

// File: rtl/reorder_buffer_mw.sv
// Reorder buffer retiring up to CMT_W done entries per cycle in order; commit is combinational
// off registered state (writeback-to-commit 1 cycle); dispatch stalls when full or recovering.
module reorder_buffer_mw #(
  parameter int DEPTH  = 8,
  parameter int CMT_W  = 2,
  parameter int XLEN   = 32,
  parameter int PREG_W = 7,
  parameter int AREG_W = 6
) (
  input logic                clk,
  input logic                rst,
  reorder_buffer_mw_if.slave rob
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [PREG_W-1:0] prd_new;
    logic [PREG_W-1:0] prd_old;
    logic [AREG_W-1:0] ard;
    logic              wb_en;
    logic              is_st;
    logic              is_ld;
  } meta_t;

  meta_t            meta [DEPTH];
  logic [XLEN-1:0]  data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             recovery_q;

  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [IDX_W-1:0] mis_off;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] slot;
  logic             mis_ok;
  logic             alloc;
  logic             wb_ok;
  logic             chain;
  logic             prev_st;
  logic             st_any;
  logic [1:0]       ld_cnt;
  logic [CMT_W-1:0] fire;
  logic [PTR_W-1:0] n_fire;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] retire_m;
  logic [DEPTH-1:0] alloc_m;
  logic [DEPTH-1:0] wb_m;

  assign count        = tail - head;
  assign head_idx     = head[IDX_W-1:0];
  assign tail_idx     = tail[IDX_W-1:0];
  assign rob.count    = count;
  assign rob.dp_idx   = tail_idx;
  assign rob.dp_ready = (count < PTR_W'(DEPTH)) && !recovery_q;
  assign rob.recovery = recovery_q;
  assign rob.flush_mask = flush;

  assign alloc   = rob.dp_valid && rob.dp_ready && !rob.mis_valid;
  assign mis_ok  = rob.mis_valid && valid[rob.mis_idx];
  assign mis_off = rob.mis_idx - head_idx;
  assign wb_ok   = rob.wb_valid && valid[rob.wb_idx] && !flush[rob.wb_idx];
  assign alloc_m = alloc ? (DEPTH'(1) << tail_idx) : '0;
  assign wb_m    = wb_ok ? (DEPTH'(1) << rob.wb_idx) : '0;

  // Age is the modular distance from head; anything further than the branch is younger.
  always_comb begin
    flush = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = IDX_W'(i) - head_idx;
      flush[i] = mis_ok && valid[i] && (off > mis_off);
    end
  end

  always_comb begin
    fire           = '0;
    n_fire         = '0;
    retire_m       = '0;
    ld_cnt         = '0;
    st_any         = 1'b0;
    chain          = 1'b1;
    prev_st        = 1'b0;
    slot           = '0;
    rob.cm_wb_en   = '0;
    rob.cm_prd_new = '0;
    rob.cm_prd_old = '0;
    rob.cm_ard     = '0;
    rob.cm_data    = '0;
    rob.cm_pc      = '0;
    rob.cm_inst    = '0;
    for (int k = 0; k < CMT_W; k++) begin
      slot = head_idx + IDX_W'(k);
      // Only one data-memory store port: a second store in the same cycle waits.
      fire[k] = chain && valid[slot] && done[slot] && !flush[slot] &&
                !(prev_st && meta[slot].is_st);
      chain   = fire[k];
      prev_st = meta[slot].is_st;
      if (fire[k]) begin
        retire_m[slot] = 1'b1;
        n_fire         = n_fire + PTR_W'(1);
        ld_cnt         = ld_cnt + 2'(meta[slot].is_ld);
        st_any         = st_any | meta[slot].is_st;
        rob.cm_wb_en[k]                     = meta[slot].wb_en;
        rob.cm_prd_new[k*PREG_W +: PREG_W]  = meta[slot].prd_new;
        rob.cm_prd_old[k*PREG_W +: PREG_W]  = meta[slot].prd_old;
        rob.cm_ard[k*AREG_W +: AREG_W]      = meta[slot].ard;
        rob.cm_data[k*XLEN +: XLEN]         = data[slot];
        rob.cm_pc[k*XLEN +: XLEN]           = meta[slot].pc;
        rob.cm_inst[k*XLEN +: XLEN]         = meta[slot].inst;
      end
    end
    rob.cm_valid  = fire;
    rob.ld_commit = ld_cnt;
    rob.st_commit = st_any;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      valid      <= '0;
      done       <= '0;
      recovery_q <= 1'b0;
    end else begin
      recovery_q <= mis_ok;
      head       <= head + n_fire;
      // Rewinding from head keeps the wrap bit consistent, so count never exceeds DEPTH.
      if (mis_ok)
        tail <= head + PTR_W'(mis_off) + PTR_W'(1);
      else if (alloc)
        tail <= tail + PTR_W'(1);
      valid <= (valid | alloc_m) & ~(flush | retire_m);
      done  <= (done | wb_m) & ~(alloc_m | flush | retire_m);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc)
      meta[tail_idx] <= '{pc: rob.dp_pc, inst: rob.dp_inst, prd_new: rob.dp_prd_new,
                          prd_old: rob.dp_prd_old, ard: rob.dp_ard, wb_en: rob.dp_wb_en,
                          is_st: rob.dp_is_st, is_ld: rob.dp_is_ld};
    if (wb_ok)
      data[rob.wb_idx] <= rob.wb_data;
  end
endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Bench for reorder_buffer_mw: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer_mw;
  localparam int D  = 8;
  localparam int D2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reorder_buffer_mw_if #(.DEPTH(D),  .CMT_W(2)) ia ();
  reorder_buffer_mw_if #(.DEPTH(D2), .CMT_W(1)) ib ();

  reorder_buffer_mw #(.DEPTH(D),  .CMT_W(2)) dut_a (.clk(clk), .rst(rst), .rob(ia));
  reorder_buffer_mw #(.DEPTH(D2), .CMT_W(1)) dut_b (.clk(clk), .rst(rst), .rob(ib));

  typedef struct {
    logic [31:0] pc, inst, data;
    logic [6:0]  pn, po;
    logic [5:0]  ard;
    logic        wen, st, ld, done;
  } ment_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.dp_valid = 0; ia.dp_pc = '0; ia.dp_inst = '0; ia.dp_prd_new = '0; ia.dp_prd_old = '0;
    ia.dp_ard = '0; ia.dp_wb_en = 0; ia.dp_is_st = 0; ia.dp_is_ld = 0;
    ia.wb_valid = 0; ia.wb_idx = '0; ia.wb_data = '0; ia.mis_valid = 0; ia.mis_idx = '0;
  endtask

  task automatic idle_b();
    ib.dp_valid = 0; ib.dp_pc = '0; ib.dp_inst = '0; ib.dp_prd_new = '0; ib.dp_prd_old = '0;
    ib.dp_ard = '0; ib.dp_wb_en = 0; ib.dp_is_st = 0; ib.dp_is_ld = 0;
    ib.wb_valid = 0; ib.wb_idx = '0; ib.wb_data = '0; ib.mis_valid = 0; ib.mis_idx = '0;
  endtask

  task automatic dp_a(input logic [31:0] pc, input logic st, input logic ld);
    ia.dp_valid = 1; ia.dp_pc = pc; ia.dp_inst = pc ^ 32'h5a5a_0000;
    ia.dp_prd_new = pc[8:2]; ia.dp_prd_old = ~pc[8:2]; ia.dp_ard = pc[7:2];
    ia.dp_wb_en = !st; ia.dp_is_st = st; ia.dp_is_ld = ld;
  endtask

  task automatic do_reset();
    idle_a(); idle_b();
    rst = 0;
    tick(); tick();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_a(); idle_b();
    rst = 0;
    #1;
    n_chk++; if (ia.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", ia.count); end
    n_chk++; if (ia.dp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ia.dp_ready); end
    n_chk++; if (ia.dp_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", ia.dp_idx); end
    n_chk++; if (ia.cm_valid !== 2'b00) begin n_fail++; $display("FAIL reset_cm_valid got %b want 00", ia.cm_valid); end
    n_chk++; if ({ia.ld_commit, ia.st_commit} !== 3'b000) begin n_fail++; $display("FAIL reset_ldst got %b want 000", {ia.ld_commit, ia.st_commit}); end
    n_chk++; if (ia.flush_mask !== 8'h00) begin n_fail++; $display("FAIL reset_flush got %b want 0", ia.flush_mask); end
    n_chk++; if (ia.recovery !== 1'b0) begin n_fail++; $display("FAIL reset_recovery got %b want 0", ia.recovery); end
    n_chk++; if (ib.count !== 3'd0) begin n_fail++; $display("FAIL reset_count_b got %0d want 0", ib.count); end
    tick(); tick();
    rst = 1;
    #1;
    n_chk++; if (ia.dp_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", ia.dp_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      idle_a(); dp_a(32'h100 + 32'(i * 4), 0, 0);
      #1;
      n_chk++; if (ia.dp_idx !== 3'(i)) begin n_fail++; $display("FAIL fill_idx got %0d want %0d", ia.dp_idx, i); end
      tick();
    end
    idle_a(); dp_a(32'hfff0, 0, 0);
    #1;
    n_chk++; if (ia.dp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", ia.dp_ready); end
    tick(); idle_a();
    #1;
    n_chk++; if (ia.count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", ia.count); end
  endtask

  task automatic test_pair_commit();
    idle_a(); ia.wb_valid = 1; ia.wb_idx = 3'd1; ia.wb_data = 32'hA1;
    #1;
    n_chk++; if (ia.cm_valid !== 2'b00) begin n_fail++; $display("FAIL pair_wb1_cm got %b want 00", ia.cm_valid); end
    tick(); idle_a(); ia.wb_valid = 1; ia.wb_idx = 3'd0; ia.wb_data = 32'hA0;
    #1;
    n_chk++; if (ia.cm_valid !== 2'b00) begin n_fail++; $display("FAIL pair_wb0_cm got %b want 00", ia.cm_valid); end
    tick(); idle_a();
    #1;
    n_chk++; if (ia.cm_valid !== 2'b11) begin n_fail++; $display("FAIL pair_cm got %b want 11", ia.cm_valid); end
    n_chk++; if (ia.cm_pc !== {32'h104, 32'h100}) begin n_fail++; $display("FAIL pair_pc got %h want 0000010400000100", ia.cm_pc); end
    n_chk++; if (ia.cm_data !== {32'hA1, 32'hA0}) begin n_fail++; $display("FAIL pair_data got %h want 000000a1000000a0", ia.cm_data); end
    tick();
    n_chk++; if (ia.count !== 4'd6) begin n_fail++; $display("FAIL pair_count got %0d want 6", ia.count); end
    n_chk++; if (ia.dp_ready !== 1'b1) begin n_fail++; $display("FAIL pair_ready got %b want 1", ia.dp_ready); end
  endtask

  task automatic test_store_pair();
    do_reset();
    dp_a(32'h300, 1, 0); tick();
    idle_a(); dp_a(32'h304, 1, 0); tick();
    idle_a(); ia.wb_valid = 1; ia.wb_idx = 3'd1; tick();
    idle_a(); ia.wb_valid = 1; ia.wb_idx = 3'd0;
    #1;
    n_chk++; if (ia.cm_valid !== 2'b00) begin n_fail++; $display("FAIL st_early got %b want 00", ia.cm_valid); end
    tick(); idle_a();
    #1;
    n_chk++; if (ia.cm_valid !== 2'b01) begin n_fail++; $display("FAIL st_first_cm got %b want 01", ia.cm_valid); end
    n_chk++; if (ia.cm_pc[31:0] !== 32'h300) begin n_fail++; $display("FAIL st_first_pc got %h want 300", ia.cm_pc[31:0]); end
    n_chk++; if (ia.st_commit !== 1'b1) begin n_fail++; $display("FAIL st_first_st got %b want 1", ia.st_commit); end
    tick();
    n_chk++; if (ia.cm_valid !== 2'b01) begin n_fail++; $display("FAIL st_second_cm got %b want 01", ia.cm_valid); end
    n_chk++; if (ia.cm_pc[31:0] !== 32'h304) begin n_fail++; $display("FAIL st_second_pc got %h want 304", ia.cm_pc[31:0]); end
    tick();
    n_chk++; if (ia.count !== 4'd0) begin n_fail++; $display("FAIL st_drain got %0d want 0", ia.count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      idle_a();
      if (i < 11) dp_a(32'h400 + 32'(i * 4), 0, 0);
      if (i >= 1 && i <= 11) begin ia.wb_valid = 1; ia.wb_idx = 3'((i - 1) % 8); ia.wb_data = 32'(i); end
      tick();
    end
    idle_a();
    #1;
    n_chk++; if (ia.count !== 4'd0) begin n_fail++; $display("FAIL flush_pre_count got %0d want 0", ia.count); end
    for (int j = 0; j < 3; j++) begin
      idle_a(); dp_a(32'h500 + 32'(j * 4), 0, 0);
      #1;
      n_chk++; if (ia.dp_idx !== 3'(3 + j)) begin n_fail++; $display("FAIL flush_dp_idx got %0d want %0d", ia.dp_idx, 3 + j); end
      tick();
    end
    idle_a(); ia.mis_valid = 1; ia.mis_idx = 3'd4;
    #1;
    n_chk++; if (ia.flush_mask !== 8'b0010_0000) begin n_fail++; $display("FAIL flush_mask got %b want 00100000", ia.flush_mask); end
    tick(); idle_a(); dp_a(32'h600, 0, 0);
    #1;
    n_chk++; if (ia.recovery !== 1'b1) begin n_fail++; $display("FAIL flush_recovery got %b want 1", ia.recovery); end
    n_chk++; if (ia.dp_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", ia.dp_ready); end
    n_chk++; if (ia.dp_idx !== 3'd5) begin n_fail++; $display("FAIL flush_tail got %0d want 5", ia.dp_idx); end
    tick(); idle_a();
    #1;
    n_chk++; if (ia.count !== 4'd2) begin n_fail++; $display("FAIL flush_count got %0d want 2", ia.count); end
    n_chk++; if ({ia.recovery, ia.dp_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_after got %b want 01", {ia.recovery, ia.dp_ready}); end
  endtask

  task automatic test_mis_ignored();
    idle_a(); ia.mis_valid = 1; ia.mis_idx = 3'd7;
    #1;
    n_chk++; if (ia.flush_mask !== 8'h00) begin n_fail++; $display("FAIL mis_ign_mask got %b want 0", ia.flush_mask); end
    tick(); idle_a();
    #1;
    n_chk++; if (ia.recovery !== 1'b0) begin n_fail++; $display("FAIL mis_ign_rec got %b want 0", ia.recovery); end
    n_chk++; if (ia.count !== 4'd2) begin n_fail++; $display("FAIL mis_ign_count got %0d want 2", ia.count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin idle_a(); dp_a(32'h700 + 32'(i * 4), 0, 0); tick(); end
    idle_a();
    #1;
    n_chk++; if (ia.count !== 4'd5) begin n_fail++; $display("FAIL ar_pre_count got %0d want 5", ia.count); end
    #2;
    rst = 0;
    #1;
    n_chk++; if (ia.count !== 4'd0) begin n_fail++; $display("FAIL ar_count got %0d want 0", ia.count); end
    n_chk++; if ({ia.dp_ready, ia.dp_idx} !== 4'b1000) begin n_fail++; $display("FAIL ar_ready_idx got %b want 1000", {ia.dp_ready, ia.dp_idx}); end
    tick();
    rst = 1;
    dp_a(32'h800, 0, 0);
    #1;
    n_chk++; if (ia.dp_idx !== 3'd0) begin n_fail++; $display("FAIL ar_first_idx got %0d want 0", ia.dp_idx); end
    tick(); idle_a();
    #1;
    n_chk++; if (ia.count !== 4'd1) begin n_fail++; $display("FAIL ar_post_count got %0d want 1", ia.count); end
  endtask

  task automatic test_wrap();
    logic [31:0] expq[$];
    int outst[$];
    int sent, got, j;
    logic [31:0] want;
    logic dv;
    sent = 0; got = 0;
    do_reset();
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      idle_b();
      dv = (sent < 20) && ($urandom_range(0, 3) != 0);
      ib.dp_valid = dv; ib.dp_pc = 32'h2000 + 32'(sent * 4); ib.dp_wb_en = 1;
      if (outst.size() > 0 && $urandom_range(0, 2) != 0) begin
        j = $urandom_range(0, outst.size() - 1);
        ib.wb_valid = 1; ib.wb_idx = 2'(outst[j]); ib.wb_data = $urandom;
        outst.delete(j);
      end
      #1;
      if (ib.cm_valid[0]) begin
        want = (expq.size() > 0) ? expq.pop_front() : 32'hdead_dead;
        n_chk++; if (ib.cm_pc !== want) begin n_fail++; $display("FAIL wrap_pc got %h want %h", ib.cm_pc, want); end
        got++;
      end
      if (dv && ib.dp_ready) begin expq.push_back(ib.dp_pc); outst.push_back(int'(ib.dp_idx)); sent++; end
      tick();
    end
    idle_b();
    n_chk++; if (got !== 20 || expq.size() !== 0) begin n_fail++; $display("FAIL wrap_total got %0d left %0d want 20 left 0", got, expq.size()); end
  endtask

  task automatic test_random();
    ment_t q[$];
    ment_t e, t;
    int hidx, pm, pw, nf, eld, wi, mi, r;
    bit mrec, mok, est, erdy, dv, wv, mv;
    logic [D-1:0] emask;
    logic [31:0] wd;
    hidx = 0; mrec = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r = $urandom_range(0, 3);
      dv = ($urandom_range(0, 99) < 65);
      e.pc = $urandom; e.inst = $urandom; e.pn = 7'($urandom); e.po = 7'($urandom);
      e.ard = 6'($urandom); e.st = (r == 1); e.ld = (r == 2);
      e.wen = (r != 1) && ($urandom_range(0, 1) == 1); e.done = 0; e.data = '0;
      wv = ($urandom_range(0, 99) < 60);
      if (q.size() > 0 && $urandom_range(0, 4) != 0) wi = (hidx + $urandom_range(0, q.size() - 1)) % D;
      else wi = $urandom_range(0, D - 1);
      wd = $urandom;
      mv = ($urandom_range(0, 99) < 5);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) mi = (hidx + $urandom_range(0, q.size() - 1)) % D;
      else mi = $urandom_range(0, D - 1);
      ia.dp_valid = dv; ia.dp_pc = e.pc; ia.dp_inst = e.inst; ia.dp_prd_new = e.pn; ia.dp_prd_old = e.po;
      ia.dp_ard = e.ard; ia.dp_wb_en = e.wen; ia.dp_is_st = e.st; ia.dp_is_ld = e.ld;
      ia.wb_valid = wv; ia.wb_idx = 3'(wi); ia.wb_data = wd; ia.mis_valid = mv; ia.mis_idx = 3'(mi);
      #1;
      erdy = (q.size() < D) && !mrec;
      pm = (mi - hidx + D) % D;
      mok = mv && (pm < q.size());
      emask = '0;
      for (int p = 0; p < q.size(); p++) if (mok && p > pm) emask[(hidx + p) % D] = 1'b1;
      nf = 0;
      if (q.size() > 0 && q[0].done) nf = 1;
      if (nf == 1 && q.size() > 1 && q[1].done && !(q[0].st && q[1].st) && !(mok && pm == 0)) nf = 2;
      eld = 0; est = 0;
      for (int p = 0; p < nf; p++) begin eld += int'(q[p].ld); est |= q[p].st; end
      n_chk++; if (ia.count !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", cyc, ia.count, q.size()); end
      n_chk++; if (ia.dp_ready !== erdy || ia.dp_idx !== 3'((hidx + q.size()) % D)) begin n_fail++; $display("FAIL rnd_dp c%0d got %b/%0d want %b/%0d", cyc, ia.dp_ready, ia.dp_idx, erdy, (hidx + q.size()) % D); end
      n_chk++; if (ia.recovery !== mrec) begin n_fail++; $display("FAIL rnd_recovery c%0d got %b want %b", cyc, ia.recovery, mrec); end
      n_chk++; if (ia.flush_mask !== emask) begin n_fail++; $display("FAIL rnd_flush c%0d got %b want %b", cyc, ia.flush_mask, emask); end
      n_chk++; if (ia.cm_valid !== 2'((1 << nf) - 1)) begin n_fail++; $display("FAIL rnd_cm_valid c%0d got %b want %0d slots", cyc, ia.cm_valid, nf); end
      n_chk++; if (ia.ld_commit !== 2'(eld) || ia.st_commit !== est) begin n_fail++; $display("FAIL rnd_ldst c%0d got %0d/%b want %0d/%b", cyc, ia.ld_commit, ia.st_commit, eld, est); end
      for (int s = 0; s < nf; s++) begin
        n_chk++;
        if (ia.cm_pc[s*32 +: 32] !== q[s].pc || ia.cm_inst[s*32 +: 32] !== q[s].inst ||
            ia.cm_data[s*32 +: 32] !== q[s].data || ia.cm_prd_new[s*7 +: 7] !== q[s].pn ||
            ia.cm_prd_old[s*7 +: 7] !== q[s].po || ia.cm_ard[s*6 +: 6] !== q[s].ard ||
            ia.cm_wb_en[s] !== q[s].wen) begin
          n_fail++;
          $display("FAIL rnd_slot%0d c%0d got pc %h data %h want pc %h data %h", s, cyc,
                   ia.cm_pc[s*32 +: 32], ia.cm_data[s*32 +: 32], q[s].pc, q[s].data);
        end
      end
      pw = (wi - hidx + D) % D;
      if (wv && pw < q.size() && !(mok && pw > pm)) begin t = q[pw]; t.done = 1; t.data = wd; q[pw] = t; end
      if (mok) while (q.size() > pm + 1) void'(q.pop_back());
      repeat (nf) void'(q.pop_front());
      hidx = (hidx + nf) % D;
      if (dv && erdy && !mv) q.push_back(e);
      mrec = mok;
      tick();
    end
    idle_a();
  endtask

  initial begin
    idle_a(); idle_b();
    #1;
    test_reset();
    test_fill();
    test_pair_commit();
    test_store_pair();
    test_flush();
    test_mis_ignored();
    test_async_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer_mw.md
REORDER_BUFFER_MW -- requirements
Module: reorder_buffer_mw

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries; power of 2, 4..64.
REQ-002 SHALL have parameter CMT_W, default 2, maximum commits per cycle; legal values 1 or 2.
REQ-003 SHALL have parameter XLEN, default 32, width of data, pc and inst.
REQ-004 SHALL have parameter PREG_W, default 7, physical register index width; parameter AREG_W, default 6, architectural register index width.
REQ-005 SHALL derive IDX_W = log2(DEPTH) locally.
REQ-006 clk  in  1  the only clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-low.
REQ-008 dp_valid  in  1  dispatch request; dp_ready  out  1  entry free.
REQ-009 dp_pc, dp_inst  in  XLEN each  dispatched pc and instruction.
REQ-010 dp_prd_new, dp_prd_old  in  PREG_W each; dp_ard  in  AREG_W; dp_wb_en  in  1  writes rd; dp_is_st  in  1  store; dp_is_ld  in  1  load.
REQ-011 dp_idx  out  IDX_W  index allocated to the dispatching instruction (current tail).
REQ-012 wb_valid  in  1; wb_idx  in  IDX_W; wb_data  in  XLEN  completion of one entry.
REQ-013 mis_valid  in  1; mis_idx  in  IDX_W  mispredicted branch entry.
REQ-014 flush_mask  out  DEPTH  one bit per entry squashed by mis_valid this cycle.
REQ-015 cm_valid  out  CMT_W; cm_wb_en  out  CMT_W; cm_prd_new, cm_prd_old, cm_ard, cm_data, cm_pc, cm_inst  out  CMT_W x field width, flattened, slot 0 in the LSBs  commit ports.
REQ-016 ld_commit  out  2  loads committed this cycle (0..CMT_W); st_commit  out  1  store committed this cycle.
REQ-017 recovery  out  1  asserted the cycle after a flush; count  out  IDX_W+1  valid entries.

Function
REQ-018 SHALL be a circular buffer with head/tail pointers of IDX_W+1 bits; the extra MSB marks wrap; index = low IDX_W bits.
REQ-019 SHALL drive count = tail - head modulo 2^(IDX_W+1); full when count == DEPTH, empty when count == 0.
REQ-020 SHALL drive dp_ready = (count < DEPTH) and not recovery, from registered state only; no same-cycle commit bypass.
REQ-021 SHALL allocate on dp_valid && dp_ready && !mis_valid: write the fields, set valid=1, done=0, tail+1.
REQ-022 SHALL, on wb_valid to a valid entry, store wb_data and set done=1; wb_valid to an invalid entry SHALL be ignored.
REQ-023 Commit slot 0 SHALL fire when the head entry is valid and done; slot k>0 SHALL fire only if slot k-1 fires and entry head+k is valid and done.
REQ-024 Slot 1 SHALL NOT fire if slots 0 and 1 are both stores (single DM store port).
REQ-025 Commit outputs SHALL be combinational from registered entries; head advances by the number of fired slots; fired entries are cleared.
REQ-026 A writeback and commit of the same entry in one cycle SHALL NOT occur; done becomes visible next cycle (writeback-to-commit latency 1).
REQ-027 On mis_valid, SHALL flag in flush_mask every valid entry strictly younger than mis_idx (mis_idx+1 .. tail-1); the branch itself survives.
REQ-028 On mis_valid, SHALL clear the flagged entries and set tail to mis_idx+1 with wrap bit chosen so count stays <= DEPTH; commits of older entries the same cycle SHALL proceed.
REQ-029 Writebacks to flagged entries in the flush cycle SHALL be dropped.
REQ-030 recovery SHALL be a registered 1-cycle pulse following any mis_valid; dispatch is blocked that cycle.
REQ-031 mis_valid with mis_idx not valid SHALL be ignored (no flush, no recovery).

Reset
REQ-032 While rst is low: head=tail=0, all valid/done=0, recovery=0; hence count=0, dp_ready=1, dp_idx=0, cm_valid=0, ld_commit=0, st_commit=0, flush_mask=0.
REQ-033 Reset assertion mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-034 DEPTH=8: dispatch 8 entries, no writebacks -> count=8, dp_ready=0; dp_idx sequence 0..7.
REQ-035 Writeback idx 1 then idx 0 -> idx 0 and 1 commit together one cycle after the later writeback, cm_valid=2'b11, head=2.
REQ-036 Entries 0 and 1 are both stores, both done -> cycle 1 commits only entry 0 (st_commit=1); next cycle commits entry 1.
REQ-037 Tail=6 with wrap, head=3, mis_idx=4 -> flush_mask=8'b0010_0000 (entry 5 only), tail=5, recovery=1 next cycle, dp_ready=0 that cycle.
REQ-038 Wrap: 20 dispatch/writeback/commit streams with DEPTH=4, CMT_W=1 -> commit pc order equals dispatch order, no entry lost.
REQ-039 Drop rst to 0 while count=5 -> outputs return to REQ-032 values asynchronously; first dispatch after release gets dp_idx=0.
